// File: rtl/uart_cfg_if.sv
// uart_cfg_if -- processor-side byte interface of the configurable UART.
//
// Signals:
//   rd_uart   pop the RX FIFO head
//   wr_uart   push w_data into the TX FIFO
//   w_data    word to transmit
//   r_data    RX FIFO head (first-word fall-through), 0 while rx_empty
//   rx_empty  RX FIFO empty
//   tx_full   TX FIFO full
//
// Modports: master = processor side, slave = UART side.
interface uart_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rd_uart;
    logic                 wr_uart;
    logic [DATA_BITS-1:0] w_data;
    logic [DATA_BITS-1:0] r_data;
    logic                 rx_empty;
    logic                 tx_full;

    modport master (
        output rd_uart, wr_uart, w_data,
        input  r_data, rx_empty, tx_full
    );

    modport slave (
        input  rd_uart, wr_uart, w_data,
        output r_data, rx_empty, tx_full
    );
endinterface

// File: rtl/uart_cfg.sv
// uart_cfg -- parametrised UART: 16x oversampling receiver, transmitter,
// shared baud tick generator and one FIFO per direction.
//
// Parameters: DATA_BITS (5..8), DVSR (clocks per oversample tick, >=2),
//             STOP_TICKS (16/24/32), FIFO_AW (FIFO depth 2^FIFO_AW),
//             PARITY_ODD (parity sense when parity is compiled in).
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   rx                 serial input (idle high, asynchronous)
//   clr_err            clears the sticky error flags
//   bus (slave)        processor byte interface (see uart_cfg_if)
//   tx                 serial output (idle high)
//   frame_err          sticky: stop bit sampled low
//   parity_err         sticky: parity mismatch
//   overrun            sticky: frame completed while RX FIFO full
//
// Build option: define UART_PARITY_EN to add a parity bit after the data in
// both directions; without it frames are start+data+stop and parity_err is 0.

module uart_cfg_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wPtr_q, wPtr_d, rPtr_q, rPtr_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          doWr, doRd;

    // A write into a full FIFO is allowed only when the head leaves in the
    // same cycle; a read of an empty FIFO never happens.
    assign doWr = wr_i & (~full_q | rd_i);
    assign doRd = rd_i & ~empty_q;

    always_ff @(posedge clk) begin
        if (doWr) mem_q[wPtr_q] <= wdata_i;
    end

    always_comb begin
        wPtr_d  = wPtr_q;
        rPtr_d  = rPtr_q;
        full_d  = full_q;
        empty_d = empty_q;
        case ({doWr, doRd})
            2'b10: begin
                wPtr_d  = wPtr_q + 1'b1;
                empty_d = 1'b0;
                full_d  = ((wPtr_q + 1'b1) == rPtr_q);
            end
            2'b01: begin
                rPtr_d  = rPtr_q + 1'b1;
                full_d  = 1'b0;
                empty_d = ((rPtr_q + 1'b1) == wPtr_q);
            end
            2'b11: begin
                wPtr_d = wPtr_q + 1'b1;
                rPtr_d = rPtr_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wPtr_q  <= '0;
            rPtr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wPtr_q  <= wPtr_d;
            rPtr_q  <= rPtr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign rdata_o = empty_q ? '0 : mem_q[rPtr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

module uart_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int DVSR       = 163,
    parameter int STOP_TICKS = 16,
    parameter int FIFO_AW    = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx,
    input  logic      clr_err,
    uart_cfg_if.slave bus,
    output logic      tx,
    output logic      frame_err,
    output logic      parity_err,
    output logic      overrun
);
    localparam int   CW        = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int   TW        = 5;   // tick counters reach STOP_TICKS-1 <= 31
    localparam int   NW        = 3;   // data bit index reaches DATA_BITS-1 <= 7
    localparam logic PAR_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rxState_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } txState_t;

    // Baud tick: one-cycle pulse every DVSR clocks, shared by RX and TX.
    logic [CW-1:0] baudCnt_q, baudCnt_d;
    logic          tick;

    assign tick      = (baudCnt_q == CW'(DVSR - 1));
    assign baudCnt_d = tick ? '0 : baudCnt_q + 1'b1;

    // Two-flop synchroniser plus one more flop to spot the falling edge.
    logic rxMeta_q, rxSync_q, rxPrev_q, rxFall;
    assign rxFall = rxPrev_q & ~rxSync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baudCnt_q <= '0;
            rxMeta_q  <= 1'b1;
            rxSync_q  <= 1'b1;
            rxPrev_q  <= 1'b1;
        end else begin
            baudCnt_q <= baudCnt_d;
            rxMeta_q  <= rx;
            rxSync_q  <= rxMeta_q;
            rxPrev_q  <= rxSync_q;
        end
    end

    // FIFOs
    logic                 rxPush, rxFull, rxEmpty;
    logic [DATA_BITS-1:0] rxHead;
    logic                 txPop, txFull, txEmpty;
    logic [DATA_BITS-1:0] txHead;
    logic [DATA_BITS-1:0] rxShift_q, rxShift_d;

    uart_cfg_fifo #(.DW(DATA_BITS), .AW(FIFO_AW)) rxFifo (
        .clk(clk), .reset(reset),
        .wr_i(rxPush), .wdata_i(rxShift_q), .rd_i(bus.rd_uart),
        .rdata_o(rxHead), .full_o(rxFull), .empty_o(rxEmpty)
    );

    uart_cfg_fifo #(.DW(DATA_BITS), .AW(FIFO_AW)) txFifo (
        .clk(clk), .reset(reset),
        .wr_i(bus.wr_uart), .wdata_i(bus.w_data), .rd_i(txPop),
        .rdata_o(txHead), .full_o(txFull), .empty_o(txEmpty)
    );

    assign bus.r_data   = rxHead;
    assign bus.rx_empty = rxEmpty;
    assign bus.tx_full  = txFull;

    // Receiver: start bit checked at its middle (tick 7), every later bit
    // sampled 16 ticks after the previous one; rxDone marks the stop sample.
    rxState_t      rxState_q, rxState_d;
    logic [TW-1:0] rxTick_q, rxTick_d;
    logic [NW-1:0] rxBitN_q, rxBitN_d;
    logic          rxDone;
`ifdef UART_PARITY_EN
    logic          rxParBad_q, rxParBad_d;
`endif

    always_comb begin
        rxState_d = rxState_q;
        rxTick_d  = rxTick_q;
        rxBitN_d  = rxBitN_q;
        rxShift_d = rxShift_q;
        rxDone    = 1'b0;
`ifdef UART_PARITY_EN
        rxParBad_d = rxParBad_q;
`endif
        case (rxState_q)
            RX_IDLE: begin
                if (rxFall) begin
                    rxState_d = RX_START;
                    rxTick_d  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rxTick_q == TW'(7)) begin
                        if (!rxSync_q) begin
                            rxState_d = RX_DATA;
                            rxTick_d  = '0;
                            rxBitN_d  = '0;
                        end else begin
                            rxState_d = RX_IDLE;
                        end
                    end else begin
                        rxTick_d = rxTick_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rxTick_q == TW'(15)) begin
                        rxTick_d  = '0;
                        rxShift_d = {rxSync_q, rxShift_q[DATA_BITS-1:1]};
                        if (rxBitN_q == NW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            rxState_d = RX_PARITY;
`else
                            rxState_d = RX_STOP;
`endif
                        end else begin
                            rxBitN_d = rxBitN_q + 1'b1;
                        end
                    end else begin
                        rxTick_d = rxTick_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (rxTick_q == TW'(15)) begin
                        rxTick_d   = '0;
                        rxParBad_d = rxSync_q ^ (^rxShift_q) ^ PAR_SENSE;
                        rxState_d  = RX_STOP;
                    end else begin
                        rxTick_d = rxTick_q + 1'b1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (rxTick_q == TW'(STOP_TICKS - 1)) begin
                        rxDone    = 1'b1;
                        rxState_d = RX_IDLE;
                    end else begin
                        rxTick_d = rxTick_q + 1'b1;
                    end
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // A word finishing into a full FIFO is dropped and flagged instead.
    assign rxPush = rxDone & ~rxFull;

    // Transmitter: tx is registered; a pop happens from IDLE or straight out
    // of the last stop tick so consecutive frames have no idle gap.
    txState_t             txState_q, txState_d;
    logic [TW-1:0]        txTick_q, txTick_d;
    logic [NW-1:0]        txBitN_q, txBitN_d;
    logic [DATA_BITS-1:0] txShift_q, txShift_d;
    logic                 txBit_q, txBit_d;
`ifdef UART_PARITY_EN
    logic                 txPar_q, txPar_d;
`endif

    always_comb begin
        txState_d = txState_q;
        txTick_d  = txTick_q;
        txBitN_d  = txBitN_q;
        txShift_d = txShift_q;
        txBit_d   = txBit_q;
        txPop     = 1'b0;
`ifdef UART_PARITY_EN
        txPar_d = txPar_q;
`endif
        case (txState_q)
            TX_IDLE: begin
                if (!txEmpty) txPop = 1'b1;
            end
            TX_START: begin
                if (tick) begin
                    if (txTick_q == TW'(15)) begin
                        txState_d = TX_DATA;
                        txTick_d  = '0;
                        txBitN_d  = '0;
                        txBit_d   = txShift_q[0];
                    end else begin
                        txTick_d = txTick_q + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (txTick_q == TW'(15)) begin
                        txTick_d  = '0;
                        txShift_d = txShift_q >> 1;
                        if (txBitN_q == NW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            txState_d = TX_PARITY;
                            txBit_d   = txPar_q;
`else
                            txState_d = TX_STOP;
                            txBit_d   = 1'b1;
`endif
                        end else begin
                            txBitN_d = txBitN_q + 1'b1;
                            txBit_d  = txShift_q[1];
                        end
                    end else begin
                        txTick_d = txTick_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    if (txTick_q == TW'(15)) begin
                        txState_d = TX_STOP;
                        txTick_d  = '0;
                        txBit_d   = 1'b1;
                    end else begin
                        txTick_d = txTick_q + 1'b1;
                    end
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    if (txTick_q == TW'(STOP_TICKS - 1)) begin
                        if (!txEmpty) txPop = 1'b1;
                        else          txState_d = TX_IDLE;
                    end else begin
                        txTick_d = txTick_q + 1'b1;
                    end
                end
            end
            default: txState_d = TX_IDLE;
        endcase

        if (txPop) begin
            txState_d = TX_START;
            txTick_d  = '0;
            txShift_d = txHead;
            txBit_d   = 1'b0;
`ifdef UART_PARITY_EN
            txPar_d = (^txHead) ^ PAR_SENSE;
`endif
        end
    end

    // Sticky errors: a new event outranks a simultaneous clear.
    logic frameErr_q, overrun_q;
`ifdef UART_PARITY_EN
    logic parErr_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxState_q  <= RX_IDLE;
            rxTick_q   <= '0;
            rxBitN_q   <= '0;
            rxShift_q  <= '0;
            txState_q  <= TX_IDLE;
            txTick_q   <= '0;
            txBitN_q   <= '0;
            txShift_q  <= '0;
            txBit_q    <= 1'b1;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rxParBad_q <= 1'b0;
            txPar_q    <= 1'b0;
            parErr_q   <= 1'b0;
`endif
        end else begin
            rxState_q  <= rxState_d;
            rxTick_q   <= rxTick_d;
            rxBitN_q   <= rxBitN_d;
            rxShift_q  <= rxShift_d;
            txState_q  <= txState_d;
            txTick_q   <= txTick_d;
            txBitN_q   <= txBitN_d;
            txShift_q  <= txShift_d;
            txBit_q    <= txBit_d;
            frameErr_q <= (rxDone & ~rxSync_q) | (frameErr_q & ~clr_err);
            overrun_q  <= (rxDone & rxFull) | (overrun_q & ~clr_err);
`ifdef UART_PARITY_EN
            rxParBad_q <= rxParBad_d;
            txPar_q    <= txPar_d;
            parErr_q   <= (rxPush & rxParBad_q) | (parErr_q & ~clr_err);
`endif
        end
    end

    assign tx        = txBit_q;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
    assign parity_err = parErr_q;
`else
    // PAR_SENSE only matters with parity compiled in; folding it into the
    // constant keeps the parameter referenced in this build as well.
    assign parity_err = PAR_SENSE & 1'b0;
`endif
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg -- scoreboard bench for uart_cfg (DVSR=2, 8 data bits, 1 stop,
// 4-deep FIFOs). Received words are checked by a monitor that pops the RX
// FIFO against a queue of expected words filled by the stimulus.
module tb_uart_cfg;
    localparam int DATA_BITS  = 8;
    localparam int DVSR       = 2;
    localparam int STOP_TICKS = 16;
    localparam int FIFO_AW    = 2;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CYC    = 16 * DVSR;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxDrv = 1'b1;
    logic loop = 1'b0;
    logic clr_err = 1'b0;
    logic rxLine;
    logic tx, frame_err, parity_err, overrun;

    int         nChecks = 0;
    int         nFails  = 0;
    int         cyc;
    bit         monEn   = 1'b0;
    logic [7:0] expQ[$];

    uart_cfg_if #(.DATA_BITS(DATA_BITS)) bus ();

    assign rxLine = loop ? tx : rxDrv;

    uart_cfg #(
        .DATA_BITS(DATA_BITS), .DVSR(DVSR), .STOP_TICKS(STOP_TICKS),
        .FIFO_AW(FIFO_AW), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .reset(reset), .rx(rxLine), .clr_err(clr_err),
        .bus(bus), .tx(tx), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; with DVSR=2 the tick is high when odd.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic goodPar(logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Drive one serial frame on rx followed by two idle bit times.
    task automatic applyStimulus(logic [7:0] data, logic stopBit, logic parBit);
        rxDrv = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rxDrv = data[i];
            repeat (BIT_CYC) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rxDrv = parBit;
        repeat (BIT_CYC) @(negedge clk);
`endif
        rxDrv = stopBit;
        repeat (BIT_CYC) @(negedge clk);
        rxDrv = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
    endtask

    task automatic writeTx(logic [7:0] d);
        bus.wr_uart = 1'b1;
        bus.w_data  = d;
        @(negedge clk);
        bus.wr_uart = 1'b0;
    endtask

    task automatic pulseClr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Wait until every expected word was popped; an expired budget counts.
    task automatic waitDrain(int budget, string name);
        int n = 0;
        while ((expQ.size() != 0 || !bus.rx_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, (n >= budget), 0);
    endtask

    // Monitor: pops one word per cycle while enabled and compares.
    initial begin
        logic [7:0] exp;
        bus.rd_uart = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_uart = 1'b0;
            if (monEn && !bus.rx_empty) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpectedWord: got 0x%0h, expected none", bus.r_data);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("rxWord", bus.r_data, exp);
                end
                bus.rd_uart = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lowCnt;
        int n;
        bus.wr_uart = 1'b0;
        bus.w_data  = '0;

        // Reset values, sampled while reset is held.
        repeat (2) @(negedge clk);
        checkOutput("rstTx", tx, 1);
        checkOutput("rstRxEmpty", bus.rx_empty, 1);
        checkOutput("rstTxFull", bus.tx_full, 0);
        checkOutput("rstRData", bus.r_data, 0);
        checkOutput("rstFrameErr", frame_err, 0);
        checkOutput("rstParityErr", parity_err, 0);
        checkOutput("rstOverrun", overrun, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Loopback: start the write on an even cycle so the start bit spans
        // exactly 16 ticks (32 cycles).
        $display("[TB] loopback 0xA5, 0x3C");
        loop  = 1'b1;
        monEn = 1'b1;
        while (cyc % 2 != 0) @(negedge clk);
        expQ.push_back(8'hA5);
        bus.wr_uart = 1'b1;
        bus.w_data  = 8'hA5;
        @(negedge clk);
        expQ.push_back(8'h3C);
        bus.w_data = 8'h3C;
        @(negedge clk);
        bus.wr_uart = 1'b0;
        lowCnt = 0;
        while (tx == 1'b0 && lowCnt < 100) begin
            lowCnt++;
            @(negedge clk);
        end
        checkOutput("startBitLen", lowCnt, 32);
        waitDrain(2000, "loopbackDrainTimeout");
        checkOutput("lbFrameErr", frame_err, 0);
        checkOutput("lbOverrun", overrun, 0);
        checkOutput("lbParityErr", parity_err, 0);
        checkOutput("lbRxEmpty", bus.rx_empty, 1);
        loop  = 1'b0;
        monEn = 1'b0;

        // Overrun: five frames into a four-word FIFO.
        $display("[TB] overrun");
        for (int i = 0; i < 5; i++) begin
            logic [7:0] w;
            w = 8'h11 * (i + 1);
            if (i < 4) expQ.push_back(w);
            applyStimulus(w, 1'b1, goodPar(w));
        end
        checkOutput("overrunSet", overrun, 1);
        checkOutput("ovFrameErr", frame_err, 0);
        checkOutput("ovRxEmpty", bus.rx_empty, 0);
        pulseClr();
        checkOutput("overrunClr", overrun, 0);
        monEn = 1'b1;
        waitDrain(200, "overrunDrainTimeout");

        // Framing error: word still delivered.
        $display("[TB] framing error");
        expQ.push_back(8'h55);
        applyStimulus(8'h55, 1'b0, goodPar(8'h55));
        waitDrain(200, "frameDrainTimeout");
        checkOutput("frameErrSet", frame_err, 1);
        pulseClr();
        checkOutput("frameErrClr", frame_err, 0);

        // Glitch of 4 ticks must be rejected, then a real frame still works.
        $display("[TB] glitch reject");
        rxDrv = 1'b0;
        repeat (4 * DVSR) @(negedge clk);
        rxDrv = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        checkOutput("glitchRxEmpty", bus.rx_empty, 1);
        expQ.push_back(8'h96);
        applyStimulus(8'h96, 1'b1, goodPar(8'h96));
        waitDrain(200, "glitchDrainTimeout");

`ifdef UART_PARITY_EN
        $display("[TB] parity");
        expQ.push_back(8'h01);
        applyStimulus(8'h01, 1'b1, 1'b0);
        waitDrain(200, "parBadDrainTimeout");
        checkOutput("parityErrSet", parity_err, 1);
        pulseClr();
        checkOutput("parityErrClr", parity_err, 0);
        expQ.push_back(8'h01);
        applyStimulus(8'h01, 1'b1, 1'b1);
        waitDrain(200, "parGoodDrainTimeout");
        checkOutput("parityOk", parity_err, 0);
`else
        checkOutput("parityTiedLow", parity_err, 0);
`endif

        // TX FIFO fill while busy: fifth write ignored.
        $display("[TB] tx full");
        loop = 1'b1;
        expQ.push_back(8'hB0);
        writeTx(8'hB0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] w;
            w = 8'hC1 + i[7:0];
            if (i == 3) checkOutput("txNotFull3", bus.tx_full, 0);
            if (i == 4) checkOutput("txFullAfter4", bus.tx_full, 1);
            if (i < 4) expQ.push_back(w);
            bus.wr_uart = 1'b1;
            bus.w_data  = w;
            @(negedge clk);
        end
        bus.wr_uart = 1'b0;
        checkOutput("txFullHold", bus.tx_full, 1);
        waitDrain(3000, "txFullDrainTimeout");
        repeat (400) @(negedge clk);
        checkOutput("txFullNoExtra", bus.rx_empty, 1);

        // Reset in the middle of a frame.
        $display("[TB] reset mid-frame");
        monEn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.wr_uart = 1'b1;
            bus.w_data  = 8'hE0 + i[7:0];
            @(negedge clk);
        end
        bus.wr_uart = 1'b0;
        n = 0;
        while (bus.rx_empty && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstFrame1Arrived", bus.rx_empty, 0);
        n = 0;
        while (tx == 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstFrame2Started", tx, 0);
        writeTx(8'hE5);
        checkOutput("preRstTxFull", bus.tx_full, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstTx", tx, 1);
        checkOutput("midRstTxFull", bus.tx_full, 0);
        checkOutput("midRstRxEmpty", bus.rx_empty, 1);
        checkOutput("midRstRData", bus.r_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        loop  = 1'b0;
        repeat (4 * BIT_CYC) @(negedge clk);
        checkOutput("postRstRxEmpty", bus.rx_empty, 1);
        checkOutput("postRstTx", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/uart_cfg.md
# uart_cfg

Parametrised UART successor: oversampling receiver, transmitter, internal baud-rate generator, and one FIFO per direction, all in one block. Generalises the fixed 8N1 UART with:
- configurable data width, stop length, FIFO depth and baud divisor;
- optional parity;
- sticky framing/parity/overrun error flags.

It sits between the serial pins and the processor-side byte interface, replacing the fixed UART.

## Interface
- DATA_BITS, 8: data bits per frame (5..8), LSB first.
- DVSR, 163: clock cycles per oversample tick (≥2); bit time = 16·DVSR cycles.
- STOP_TICKS, 16: stop length in ticks (16 = 1 stop, 24 = 1.5 stop, 32 = 2 stop).
- FIFO_AW, 2: FIFO address width; each FIFO holds 2^FIFO_AW words.
- PARITY_ODD, 0: parity sense when parity is compiled in (0 even, 1 odd).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- rd_uart  in  1  pop the RX FIFO head.
- wr_uart  in  1  push w_data into the TX FIFO.
- w_data  in  DATA_BITS  byte to transmit.
- clr_err  in  1  clears all sticky error flags.
- r_data  out  DATA_BITS  RX FIFO head (first-word fall-through); 0 while rx_empty.
- rx_empty  out  1  RX FIFO empty.
- tx_full  out  1  TX FIFO full.
- tx  out  1  serial output, idle high.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: frame completed while RX FIFO full.

## Operation
- Reset values:
  - tx=1, rx_empty=1, tx_full=0, r_data=0;
  - all error flags 0;
  - both FSMs idle, FIFOs emptied, tick counter 0, rx synchroniser flops 1.
- Rate generator:
  - counter 0..DVSR-1 wraps;
  - `tick` is high for one cycle when counter = DVSR-1.
- rx passes through a 2-flop synchroniser before use.
- Receiver FSM: IDLE → START → DATA → PARITY (if compiled) → STOP → IDLE.
  - IDLE: falling edge on the synchronised rx → START, tick count cleared.
  - START: at tick 7, rx still low → DATA; rx high → IDLE (glitch reject).
  - DATA: sample every 16 ticks, shift right; after DATA_BITS samples → PARITY or STOP.
  - PARITY: sample after 16 ticks; compare with the XOR of the data bits (XOR 1 when PARITY_ODD).
  - STOP: sample after STOP_TICKS ticks. Stop low sets frame_err, but the word is still pushed.
- RX push on stop sample:
  - FIFO not full: push; parity mismatch sets parity_err.
  - FIFO full: word dropped, overrun set, FIFO unchanged.
- Transmitter FSM: IDLE → START → DATA → PARITY (if compiled) → STOP → IDLE.
  - IDLE with TX FIFO non-empty: pop the head into the shift register in the same cycle → START, tx=0.
  - Each bit is held 16 ticks; the stop bit is held STOP_TICKS ticks with tx=1.
  - Back-to-back frames have no extra idle gap.
- FIFOs:
  - write while full is ignored; read while empty is ignored;
  - full with simultaneous rd+wr: both occur, stays full;
  - empty with simultaneous rd+wr: write only;
  - pointers wrap modulo 2^FIFO_AW.
- Errors:
  - clr_err clears all flags next cycle;
  - an error event in the same cycle as clr_err wins (flag set).

## Timing
- tx_full/rx_empty update the cycle after the causing rd/wr edge.
- wr_uart at cycle n into an idle, empty transmitter:
  - TX FIFO non-empty at n+1; pop at n+1;
  - tx falls at n+2, with no tick alignment required for the start edge;
  - each later bit boundary lands on tick edges (16·DVSR cycles per bit).
- RX latency: rx_empty falls 1 cycle after the stop-sample tick (3 cycles after rx input counting the synchroniser).
- reset mid-frame: tx returns high in the same cycle (async); partial RX word discarded.

## Configuration
- UART_PARITY_EN defined: one parity bit follows the data in both directions; PARITY_ODD selects the sense; parity_err is live.
- UART_PARITY_EN undefined: no PARITY state in either FSM, frames are start+data+stop, parity_err is tied 0.

## Test plan
- Loopback (tx→rx), DVSR=2, push 0xA5, 0x3C → rx pops 0xA5 then 0x3C, no error flags; tx low for exactly 32 cycles during the start bit.
- Send 4+1 frames without reading (FIFO_AW=2) → first 4 words retained, overrun=1, fifth word lost; clr_err → overrun=0.
- Drive a frame with stop bit 0 carrying 0x55 → r_data=0x55, frame_err=1.
- UART_PARITY_EN, PARITY_ODD=0, inject 0x01 with parity bit 0 → parity_err=1; with parity 1 → no error.
- rx low pulse of 4 ticks → receiver returns to IDLE, rx_empty stays 1.
- Write 5 words rapidly with the transmitter busy → tx_full=1 after 4, fifth ignored; assert reset mid-frame → tx=1, tx_full=0, rx_empty=1 immediately.
